// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed wait-state memory behind the MAR/MDR port
//
// Purpose:
//   Internal 32-bit RAM of 2**ADDR_W words serving Read/Write requests from the
//   control sequencer. An access starts on the rising edge of Read or Write.
//   It completes after WAIT_STATES extra busy cycles with a one-cycle MemReady pulse.
//
// Parameters:
//   ADDR_W      word-address width (RAM depth 2**ADDR_W)
//   WAIT_STATES extra busy cycles per access, 0..15
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-low reset
//   Read      read request level
//   Write     write request level
//   MARaddr   word address; bits [ADDR_W-1:0] index the RAM
//   MDRdata   write data
//   Mdatain   read data, held until the next completed read
//   MemReady  one-cycle completion pulse
//   MemErr    one-cycle error pulse, coincident with MemReady
//
// Configuration macro:
//   MEM_ADDR_CHECK_EN  when defined, a nonzero MARaddr[31:ADDR_W] suppresses the
//                      access and flags MemErr; otherwise addresses alias.

module memory_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] MARaddr,
    input  logic [31:0] MDRdata,
    output logic [31:0] Mdatain,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic                is_wr_q,  is_wr_d;
    logic                err_q,    err_d;
    logic                rd_prev_q, rd_prev_d;
    logic                wr_prev_q, wr_prev_d;
    logic [31:0]         mdat_q,   mdat_d;
    logic                ready_q,  ready_d;
    logic                merr_q,   merr_d;

    logic [31:0] ram [0:DEPTH-1];

    logic rd_rise;
    logic wr_rise;
    logic addr_bad;
    logic ram_we;

    assign rd_rise = Read  & ~rd_prev_q;
    assign wr_rise = Write & ~wr_prev_q;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = |MARaddr[31:ADDR_W];
`else
    // Upper address bits alias onto the RAM and are deliberately unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^MARaddr[31:ADDR_W];
    assign addr_bad = 1'b0;
`endif

    // The RAM is touched only on the BUSY->DONE edge of a clean write.
    assign ram_we = (state_q == BUSY) && (cnt_q == 4'd0) && is_wr_q && !err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        err_d     = err_q;
        mdat_d    = mdat_q;
        ready_d   = ready_q;
        merr_d    = merr_q;
        rd_prev_d = Read;
        wr_prev_d = Write;

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                merr_d  = 1'b0;
                if (rd_rise || wr_rise) begin
                    state_d = BUSY;
                    cnt_d   = 4'(WAIT_STATES);
                    addr_d  = MARaddr[ADDR_W-1:0];
                    wdata_d = MDRdata;
                    is_wr_d = wr_rise && !rd_rise;
                    // Simultaneous Read/Write still runs the handshake, but as an error.
                    err_d   = (rd_rise && wr_rise) || addr_bad;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    merr_d  = err_q;
                    if (!is_wr_q && !err_q) begin
                        mdat_d = ram[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b0;
                merr_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                merr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            mdat_q    <= 32'd0;
            ready_q   <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            mdat_q    <= mdat_d;
            ready_q   <= ready_d;
            merr_q    <= merr_d;
        end
    end

    // RAM contents survive reset; the clr term guards a reset landing on the write edge.
    always_ff @(posedge clk) begin
        if (ram_we && clr) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign Mdatain  = mdat_q;
    assign MemReady = ready_q;
    assign MemErr   = merr_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder

module tb_memory_responder;

    localparam int ADDR_W = 9;
    localparam int WS     = 1;
`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] MARaddr = 32'd0;
    logic [31:0] MDRdata = 32'd0;
    logic [31:0] Mdatain;
    logic        MemReady;
    logic        MemErr;

    memory_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .clr      (clr),
        .Read     (Read),
        .Write    (Write),
        .MARaddr  (MARaddr),
        .MDRdata  (MDRdata),
        .Mdatain  (Mdatain),
        .MemReady (MemReady),
        .MemErr   (MemErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] mdat_m = 32'd0;
    int          checks = 0;
    int          passes = 0;
    int          pulse_cnt = 0;
    int          exp_total = 0;

    always @(negedge clk) if (MemReady === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Push the model's expected completion for a request about to be driven.
    task automatic push_expect(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data);
        int   idx;
        logic bad;
        logic err;
        idx = int'(addr[ADDR_W-1:0]);
        bad = CHK && (addr[31:ADDR_W] != '0);
        err = (rd && wr) || bad;
        if (!err && wr) mem_m[idx] = data;
        if (!err && rd && !wr) mdat_m = mem_m.exists(idx) ? mem_m[idx] : 32'hx;
        exp_q.push_back('{err: err, data: mdat_m});
        exp_total++;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_ready"}, {31'd0, MemReady}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_err"},  {31'd0, MemErr}, {31'd0, e.err});
            check({tag, "_data"}, Mdatain, e.data);
        end
    endtask

    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data, input int hold);
        @(negedge clk);
        Read = rd; Write = wr; MARaddr = addr; MDRdata = data;
        push_expect(rd, wr, addr, data);
        for (int c = 1; c <= hold || c <= WS + 4; c++) begin
            @(negedge clk);
            if (c == hold) begin Read = 1'b0; Write = 1'b0; end
            if (c == WS + 1) check({tag, "_early"}, {31'd0, MemReady}, 32'd0);
            if (c == WS + 2) pop_compare(tag);
            if (c == WS + 3) check({tag, "_pulse1"}, {30'd0, MemReady, MemErr}, 32'd0);
        end
    endtask

    initial begin
        bit saw_ready;

        repeat (2) @(negedge clk);
        check("rst_mdat",  Mdatain, 32'd0);
        check("rst_ready", {31'd0, MemReady}, 32'd0);
        check("rst_err",   {31'd0, MemErr}, 32'd0);
        clr = 1'b1;
        @(negedge clk);

        access("wr12", 1'b0, 1'b1, 32'h12, 32'h0000000A, 1);
        access("rd12", 1'b1, 1'b0, 32'h12, 32'h0, 1);

        access("wr40", 1'b0, 1'b1, 32'h40, 32'h0000000F, 1);
        access("hold", 1'b1, 1'b0, 32'h40, 32'h0, 6);
        check("hold_mdat", Mdatain, 32'h0000000F);

        access("both", 1'b1, 1'b1, 32'h12, 32'h00000012, 1);
        access("rd12b", 1'b1, 1'b0, 32'h12, 32'h0, 1);

        // Reset one edge after a write starts: the write and its pulse vanish.
        access("wr20", 1'b0, 1'b1, 32'h20, 32'h00001234, 1);
        @(negedge clk);
        Write = 1'b1; MARaddr = 32'h20; MDRdata = 32'hDEADBEEF;
        @(negedge clk);
        clr = 1'b0; Write = 1'b0;
        #1;
        check("midrst_mdat", Mdatain, 32'd0);
        mdat_m = 32'd0;
        @(negedge clk);
        clr = 1'b1;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (MemReady !== 1'b0) saw_ready = 1'b1;
        end
        check("midrst_noready", {31'd0, saw_ready}, 32'd0);
        access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1);

        // A second Read edge while BUSY is dropped; data comes from the first address.
        access("wr30", 1'b0, 1'b1, 32'h30, 32'h00000055, 1);
        @(negedge clk);
        Read = 1'b1; MARaddr = 32'h12;
        push_expect(1'b1, 1'b0, 32'h12, 32'h0);
        @(negedge clk);
        Read = 1'b0;
        @(negedge clk);
        Read = 1'b1; MARaddr = 32'h30;
        @(negedge clk);
        pop_compare("busydrop");
        @(negedge clk);
        Read = 1'b0;
        check("busydrop_pulse1", {31'd0, MemReady}, 32'd0);
        repeat (4) @(negedge clk);
        check("busydrop_mdat", Mdatain, 32'h0000000A);

        access("addrchk", 1'b1, 1'b0, 32'h00000212, 32'h0, 1);

        repeat (3) @(negedge clk);
        check("pulse_count", pulse_cnt, exp_total);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
